mem_bus_ctrl: RTL and testbench
===============================

# mem_bus_ctrl

Memory-stage bus sequencer that sits directly behind the EXE/MEM pipeline register. It turns the registered `mem_addr/mem_data/mem_we/mem_op` fields into a single req/ack bus transaction with byte lanes. It stalls the upstream pipeline until the access completes, and returns sign- or zero-extended load data to the write-back path.

## Interface
Parameters:
- `TIMEOUT`, default 255: maximum cycles in REQ without ack or err; used only with `BUS_TIMEOUT_EN`. Legal range 1..255.

Ports:
- `clk_i`  in  1  single clock, all state on rising edge
- `rst_n_i`  in  1  asynchronous, active-low reset
- `mem_addr_i`  in  `ADDR_WIDTH`  byte address from the EXE/MEM register
- `mem_data_i`  in  `DATA_WIDTH`  store data, right-aligned
- `mem_we_i`  in  1  1 = store, 0 = load
- `mem_op_i`  in  4  `MEM_*` code from defines.v (NOP, LB, LH, LW, LBU, LHU, SB, SH, SW)
- `stall_o`  out  6  pipeline stall vector, bit0 = PC … bit5 = WB
- `mem_rdata_o`  out  `DATA_WIDTH`  extended load result
- `mem_rdata_valid_o`  out  1  one-cycle pulse when `mem_rdata_o` is valid
- `err_o`  out  1  one-cycle pulse on misalign, bus error or timeout
- `bus_req_o`  out  1  transaction request
- `bus_we_o`  out  1  write strobe
- `bus_addr_o`  out  `ADDR_WIDTH`  word address, bits [1:0] = 0
- `bus_sel_o`  out  4  byte-lane enables, bit n = byte n
- `bus_wdata_o`  out  `DATA_WIDTH`  lane-positioned write data
- `bus_ack_i`  in  1  transaction complete
- `bus_err_i`  in  1  transaction failed
- `bus_rdata_i`  in  `DATA_WIDTH`  read data, valid with ack

## Operation
- FSM states: IDLE, REQ, DONE. Reset puts the FSM in IDLE.
- IDLE, `mem_op_i` = `MEM_NOP`: stay in IDLE.
- IDLE, legal op: latch op, address and lane data; go to REQ.
- IDLE, misaligned op: no bus cycle; `err_o` pulses; go to DONE.
  - Misaligned = LH/LHU/SH with addr[0] = 1, or LW/SW with addr[1:0] ≠ 0.
- REQ: `bus_req_o` = 1; bus outputs are held stable.
  - `bus_err_i` = 1: go to DONE with an `err_o` pulse. Error has priority over a simultaneous ack.
  - else `bus_ack_i` = 1: go to DONE. For loads, capture the extended data.
- DONE: lasts one cycle, then IDLE. `mem_op_i` is ignored in DONE, so the access that just finished is never reissued.
- `stall_o` is combinational:
  - 6'b011111 while in REQ, or in IDLE with a non-NOP op.
  - 6'b000000 otherwise.
- Lanes, with b = addr[1:0]:
  - SB: sel = 1<<b; wdata = byte replicated ×4.
  - SH: sel = 0011 or 1100 by addr[1]; wdata = half replicated ×2.
  - SW: sel = 1111.
  - Loads: sel follows the same rule; bus_we = 0.
- Load extract:
  - LB/LH: sign-extend the selected lane.
  - LBU/LHU: zero-extend the selected lane.
  - LW: full word.
  - Any error: `mem_rdata_o` = 0 and no valid pulse.

## Timing
- Reset values: all outputs 0, counter 0, state IDLE.
- Reset is asynchronous: `bus_req_o` drops immediately, even mid-REQ.
- Bus outputs and the rdata/valid/err outputs are registered.
- Zero-wait access:
  - Op visible in cycle N: stall = 1.
  - Cycle N+1: `bus_req_o` = 1, ack sampled.
  - Cycle N+2: DONE, stall = 0, `mem_rdata_valid_o` = 1.
  - Pipeline stall is 2 cycles; each wait state adds 1.
- Back-to-back memory ops: IDLE → REQ → DONE → IDLE → REQ. Minimum 3 cycles per access.
- Misaligned op: stall for 1 cycle (N), `err_o` in N+1.
- Ack or err outside REQ is ignored.

## Configuration
- `BUS_TIMEOUT_EN` defined:
  - An 8-bit counter clears on entry to REQ and increments each REQ cycle.
  - When the counter reaches `TIMEOUT` without ack or err: drop the request, pulse `err_o`, go to DONE.
- `BUS_TIMEOUT_EN` undefined: no counter; REQ waits indefinitely for ack or err.

## Test plan
- LW at 0x100; ack in the first REQ cycle with rdata 0xDEADBEEF:
  - `mem_rdata_o` = 0xDEADBEEF with a valid pulse at N+2.
  - `stall_o` = 6'b011111 for exactly 2 cycles.
- LB at 0x103; rdata 0x80FF_FFFF → `mem_rdata_o` = 0xFFFFFF80.
- LBU at the same address and data → `mem_rdata_o` = 0x00000080.
- SH at 0x202 with data 0x1234, ack after 3 wait cycles:
  - `bus_addr_o` = 0x200, `bus_sel_o` = 1100, `bus_wdata_o` = 0x12341234, `bus_we_o` = 1.
  - `bus_req_o` held high for 4 cycles.
- LW at 0x101 → no `bus_req_o`, `err_o` pulse, one stall cycle, no valid pulse.
- With `BUS_TIMEOUT_EN` and `TIMEOUT` = 4, no ack → `bus_req_o` high for 4 cycles, then `err_o` pulse, `mem_rdata_o` = 0.
- `rst_n_i` low during REQ → `bus_req_o` and `stall_o` go to 0 at once. After release, a NOP op keeps the FSM in IDLE.

Source files
------------

// File: rtl/mem_bus_ctrl.sv
// Memory-stage bus sequencer: turns EXE/MEM load/store fields into one req/ack bus cycle.
// Optional REQ watchdog enabled by defining BUS_TIMEOUT_EN (limit set by TIMEOUT).
module mem_bus_ctrl #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 255
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic [ADDR_WIDTH-1:0] mem_addr_i,
  input  logic [DATA_WIDTH-1:0] mem_data_i,
  input  logic                  mem_we_i,
  input  logic [3:0]            mem_op_i,
  output logic [5:0]            stall_o,
  output logic [DATA_WIDTH-1:0] mem_rdata_o,
  output logic                  mem_rdata_valid_o,
  output logic                  err_o,
  output logic                  bus_req_o,
  output logic                  bus_we_o,
  output logic [ADDR_WIDTH-1:0] bus_addr_o,
  output logic [3:0]            bus_sel_o,
  output logic [DATA_WIDTH-1:0] bus_wdata_o,
  input  logic                  bus_ack_i,
  input  logic                  bus_err_i,
  input  logic [DATA_WIDTH-1:0] bus_rdata_i
);

  localparam int NUM_LANES = 4;
  localparam logic [3:0] MEM_NOP = 4'd0, MEM_LB  = 4'd1, MEM_LH  = 4'd2,
                         MEM_LW  = 4'd3, MEM_LBU = 4'd4, MEM_LHU = 4'd5,
                         MEM_SB  = 4'd6, MEM_SH  = 4'd7, MEM_SW  = 4'd8;

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

  state_t state_q, state_n;
  logic   start, fail, done_ok;
  logic   is_byte, is_half, is_word, misalign;
  logic [3:0]            sel_d;
  logic [DATA_WIDTH-1:0] wdata_d, ext_d;
  logic [3:0]            op_q;
  logic [1:0]            off_q;
  logic [NUM_LANES-1:0][7:0] rd_lanes;
  logic [7:0]            lane_b;
  logic [15:0]           lane_h;

  // Size decode; unknown codes count as misaligned so they error out instead of hanging.
  always_comb begin
    is_byte = 1'b0;
    is_half = 1'b0;
    is_word = 1'b0;
    case (mem_op_i)
      MEM_LB, MEM_LBU, MEM_SB: is_byte = 1'b1;
      MEM_LH, MEM_LHU, MEM_SH: is_half = 1'b1;
      MEM_LW, MEM_SW:          is_word = 1'b1;
      default: ;
    endcase
  end

  assign misalign = (is_half & mem_addr_i[0]) | (is_word & (|mem_addr_i[1:0])) |
                    (~is_byte & ~is_half & ~is_word & (mem_op_i != MEM_NOP));

  always_comb begin
    sel_d   = 4'b1111;
    wdata_d = mem_data_i;
    if (is_byte) begin
      sel_d   = 4'b0001 << mem_addr_i[1:0];
      wdata_d = {NUM_LANES{mem_data_i[7:0]}};
    end else if (is_half) begin
      sel_d   = mem_addr_i[1] ? 4'b1100 : 4'b0011;
      wdata_d = {2{mem_data_i[15:0]}};
    end
  end

  assign rd_lanes = bus_rdata_i;
  assign lane_b   = rd_lanes[off_q];
  assign lane_h   = off_q[1] ? rd_lanes[3:2] : rd_lanes[1:0];

  always_comb begin
    case (op_q)
      MEM_LB:  ext_d = {{(DATA_WIDTH-8){lane_b[7]}}, lane_b};
      MEM_LBU: ext_d = {{(DATA_WIDTH-8){1'b0}}, lane_b};
      MEM_LH:  ext_d = {{(DATA_WIDTH-16){lane_h[15]}}, lane_h};
      MEM_LHU: ext_d = {{(DATA_WIDTH-16){1'b0}}, lane_h};
      default: ext_d = bus_rdata_i;
    endcase
  end

`ifdef BUS_TIMEOUT_EN
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);
  logic [7:0] to_cnt_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i)            to_cnt_q <= '0;
    else if (start)          to_cnt_q <= '0;
    else if (state_q == REQ) to_cnt_q <= to_cnt_q + 8'd1;
  end
`endif

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) state_q <= IDLE;
    else          state_q <= state_n;
  end

  always_comb begin
    state_n = state_q;
    start   = 1'b0;
    fail    = 1'b0;
    done_ok = 1'b0;
    case (state_q)
      IDLE: if (mem_op_i != MEM_NOP) begin
        if (misalign) begin
          state_n = DONE;
          fail    = 1'b1;
        end else begin
          state_n = REQ;
          start   = 1'b1;
        end
      end
      REQ: begin
        if (bus_err_i) begin
          state_n = DONE;
          fail    = 1'b1;
        end else if (bus_ack_i) begin
          state_n = DONE;
          done_ok = 1'b1;
        end
`ifdef BUS_TIMEOUT_EN
        else if (to_cnt_q == TO_LAST) begin
          state_n = DONE;
          fail    = 1'b1;
        end
`endif
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Gated by reset so the pipeline releases the instant reset asserts.
  assign stall_o = (rst_n_i && ((state_q == REQ) || ((state_q == IDLE) && (mem_op_i != MEM_NOP))))
                   ? 6'b011111 : 6'b000000;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      bus_req_o         <= 1'b0;
      bus_we_o          <= 1'b0;
      bus_addr_o        <= '0;
      bus_sel_o         <= '0;
      bus_wdata_o       <= '0;
      mem_rdata_o       <= '0;
      mem_rdata_valid_o <= 1'b0;
      err_o             <= 1'b0;
      op_q              <= MEM_NOP;
      off_q             <= '0;
    end else begin
      bus_req_o         <= (state_n == REQ);
      mem_rdata_valid_o <= 1'b0;
      err_o             <= fail;
      if (start) begin
        op_q        <= mem_op_i;
        off_q       <= mem_addr_i[1:0];
        bus_we_o    <= mem_we_i;
        bus_addr_o  <= {mem_addr_i[ADDR_WIDTH-1:2], 2'b00};
        bus_sel_o   <= sel_d;
        bus_wdata_o <= wdata_d;
      end
      if (fail) begin
        mem_rdata_o <= '0;
      end else if (done_ok && !bus_we_o) begin
        mem_rdata_o       <= ext_d;
        mem_rdata_valid_o <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Scoreboard bench for mem_bus_ctrl: directed load/store vectors, bus-side and response monitors.
module tb_mem_bus_ctrl;
  localparam logic [3:0] NOP = 4'd0, LB = 4'd1, LH = 4'd2, LW = 4'd3, LBU = 4'd4,
                         LHU = 4'd5, SB = 4'd6, SH = 4'd7, SW = 4'd8;
  localparam int R_ACK = 0, R_ERR = 1, R_BOTH = 2, R_NONE = 3;

  logic        clk = 1'b0, rst_n = 1'b0;
  logic [31:0] mem_addr = '0, mem_data = '0, bus_rdata = '0;
  logic        mem_we = 1'b0, bus_ack = 1'b0, bus_err = 1'b0;
  logic [3:0]  mem_op = NOP;
  logic [5:0]  stall_o;
  logic [31:0] mem_rdata_o, bus_addr_o, bus_wdata_o;
  logic        mem_rdata_valid_o, err_o, bus_req_o, bus_we_o;
  logic [3:0]  bus_sel_o;

  always #5 clk = ~clk;

  mem_bus_ctrl #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT(4)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .mem_addr_i(mem_addr), .mem_data_i(mem_data),
    .mem_we_i(mem_we), .mem_op_i(mem_op), .stall_o(stall_o), .mem_rdata_o(mem_rdata_o),
    .mem_rdata_valid_o(mem_rdata_valid_o), .err_o(err_o), .bus_req_o(bus_req_o),
    .bus_we_o(bus_we_o), .bus_addr_o(bus_addr_o), .bus_sel_o(bus_sel_o),
    .bus_wdata_o(bus_wdata_o), .bus_ack_i(bus_ack), .bus_err_i(bus_err),
    .bus_rdata_i(bus_rdata)
  );

  typedef struct packed { logic is_err; logic [31:0] data; } rsp_t;
  typedef struct packed { logic [31:0] addr; logic [3:0] sel; logic [31:0] wdata; logic we; } bus_t;

  rsp_t exp_q[$];
  bus_t bus_q[$];
  int   checks = 0, errors = 0;
  logic req_prev = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Response monitor and bus-request monitor, both sampling on the falling edge.
  always @(negedge clk) begin
    if (mem_rdata_valid_o || err_o) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_rsp: got valid=%b err=%b expected no response", mem_rdata_valid_o, err_o);
      end else begin
        chk("rsp_err", 32'(err_o), 32'(exp_q[0].is_err));
        chk("rsp_valid", 32'(mem_rdata_valid_o), 32'(!exp_q[0].is_err));
        chk("rsp_data", mem_rdata_o, exp_q[0].data);
        void'(exp_q.pop_front());
      end
    end
    if (bus_req_o && !req_prev) begin
      if (bus_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_req: got bus_req addr=%h expected no request", bus_addr_o);
      end else begin
        chk("bus_addr", bus_addr_o, bus_q[0].addr);
        chk("bus_sel", 32'(bus_sel_o), 32'(bus_q[0].sel));
        chk("bus_we", 32'(bus_we_o), 32'(bus_q[0].we));
        if (bus_q[0].we) chk("bus_wdata", bus_wdata_o, bus_q[0].wdata);
        void'(bus_q.pop_front());
      end
    end
    req_prev <= bus_req_o;
  end

  // Issues one op and plays the bus slave; counts stall and request cycles.
  task automatic run_op(input string tag, input logic [3:0] op, input logic we,
                        input logic [31:0] addr, input logic [31:0] data, input int waits,
                        input int resp, input logic [31:0] rdata,
                        input int exp_stall, input int exp_req);
    int stall_n = 0, req_n = 0;
    bit done = 1'b0;
    @(negedge clk);
    mem_op = op; mem_we = we; mem_addr = addr; mem_data = data; bus_rdata = rdata;
    for (int c = 0; c < 60 && !done; c++) begin
      #1;
      if (stall_o == 6'b011111) stall_n++;
      else if (stall_o != 6'b0) chk({tag, "_stall_val"}, 32'(stall_o), 32'h1f);
      if (bus_req_o) req_n++;
      if (stall_o == 6'b0) begin
        done = 1'b1;
        mem_op = NOP; mem_we = 1'b0; bus_ack = 1'b0; bus_err = 1'b0;
      end else begin
        bus_ack = bus_req_o && (req_n == waits + 1) && (resp == R_ACK || resp == R_BOTH);
        bus_err = bus_req_o && (req_n == waits + 1) && (resp == R_ERR || resp == R_BOTH);
        @(negedge clk);
      end
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL %s_budget: got no completion expected DONE within 60 cycles", tag);
      mem_op = NOP; bus_ack = 1'b0; bus_err = 1'b0;
    end
    chk({tag, "_stall_cycles"}, 32'(stall_n), 32'(exp_stall));
    chk({tag, "_req_cycles"}, 32'(req_n), 32'(exp_req));
  endtask

  initial begin
    #12;
    chk("rst_req", 32'(bus_req_o), 0);
    chk("rst_stall", 32'(stall_o), 0);
    chk("rst_out", {mem_rdata_valid_o, err_o, bus_we_o, bus_sel_o}, 0);
    chk("rst_data", mem_rdata_o | bus_addr_o | bus_wdata_o, 0);
    @(negedge clk); rst_n = 1'b1;

    // ack while idle must be ignored
    @(negedge clk); bus_ack = 1'b1; bus_rdata = 32'hFFFF_FFFF;
    repeat (2) @(negedge clk);
    chk("idle_ack_req", 32'(bus_req_o), 0);
    bus_ack = 1'b0;

    exp_q.push_back('{1'b0, 32'hDEAD_BEEF}); bus_q.push_back('{32'h100, 4'b1111, 32'h0, 1'b0});
    run_op("lw", LW, 1'b0, 32'h100, 32'h0, 0, R_ACK, 32'hDEAD_BEEF, 2, 1);

    exp_q.push_back('{1'b0, 32'hFFFF_FF80}); bus_q.push_back('{32'h100, 4'b1000, 32'h0, 1'b0});
    run_op("lb", LB, 1'b0, 32'h103, 32'h0, 0, R_ACK, 32'h80FF_FFFF, 2, 1);

    exp_q.push_back('{1'b0, 32'h0000_0080}); bus_q.push_back('{32'h100, 4'b1000, 32'h0, 1'b0});
    run_op("lbu", LBU, 1'b0, 32'h103, 32'h0, 0, R_ACK, 32'h80FF_FFFF, 2, 1);

    bus_q.push_back('{32'h200, 4'b1100, 32'h1234_1234, 1'b1});
    run_op("sh", SH, 1'b1, 32'h202, 32'h1234, 3, R_ACK, 32'h0, 5, 4);

    exp_q.push_back('{1'b1, 32'h0});
    run_op("lw_mis", LW, 1'b0, 32'h101, 32'h0, 0, R_ACK, 32'h0, 1, 0);

    exp_q.push_back('{1'b0, 32'hFFFF_8001}); bus_q.push_back('{32'h100, 4'b1100, 32'h0, 1'b0});
    run_op("lh", LH, 1'b0, 32'h102, 32'h0, 1, R_ACK, 32'h8001_0000, 3, 2);

    exp_q.push_back('{1'b0, 32'h0000_F00D}); bus_q.push_back('{32'h100, 4'b0011, 32'h0, 1'b0});
    run_op("lhu", LHU, 1'b0, 32'h100, 32'h0, 0, R_ACK, 32'h1234_F00D, 2, 1);

    bus_q.push_back('{32'h200, 4'b0010, 32'hA5A5_A5A5, 1'b1});
    run_op("sb", SB, 1'b1, 32'h201, 32'h0000_00A5, 0, R_ACK, 32'h0, 2, 1);

    bus_q.push_back('{32'h204, 4'b1111, 32'hCAFE_F00D, 1'b1});
    run_op("sw", SW, 1'b1, 32'h204, 32'hCAFE_F00D, 2, R_ACK, 32'h0, 4, 3);

    exp_q.push_back('{1'b1, 32'h0}); bus_q.push_back('{32'h108, 4'b1111, 32'h0, 1'b0});
    run_op("lw_berr", LW, 1'b0, 32'h108, 32'h0, 0, R_ERR, 32'h1111_1111, 2, 1);

    exp_q.push_back('{1'b1, 32'h0}); bus_q.push_back('{32'h10C, 4'b1111, 32'h0, 1'b0});
    run_op("lw_both", LW, 1'b0, 32'h10C, 32'h0, 0, R_BOTH, 32'h2222_2222, 2, 1);

    exp_q.push_back('{1'b1, 32'h0});
    run_op("sh_mis", SH, 1'b1, 32'h203, 32'h5555, 0, R_ACK, 32'h0, 1, 0);

    exp_q.push_back('{1'b0, 32'h0000_007F}); bus_q.push_back('{32'h100, 4'b0001, 32'h0, 1'b0});
    run_op("lb_pos", LB, 1'b0, 32'h100, 32'h0, 0, R_ACK, 32'h0000_007F, 2, 1);

`ifdef BUS_TIMEOUT_EN
    exp_q.push_back('{1'b1, 32'h0}); bus_q.push_back('{32'h110, 4'b1111, 32'h0, 1'b0});
    run_op("lw_tmo", LW, 1'b0, 32'h110, 32'h0, 0, R_NONE, 32'h0, 5, 4);
`endif

    // reset asserted in the middle of REQ
    @(negedge clk);
    bus_q.push_back('{32'h120, 4'b1111, 32'h0, 1'b0});
    mem_op = LW; mem_addr = 32'h120; mem_data = 32'h0;
    for (int c = 0; c < 10 && !bus_req_o; c++) @(negedge clk);
    chk("mid_req_seen", 32'(bus_req_o), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_req", 32'(bus_req_o), 0);
    chk("async_rst_stall", 32'(stall_o), 0);
    @(negedge clk); mem_op = NOP; rst_n = 1'b1;
    begin
      int bad = 0;
      repeat (4) begin
        @(negedge clk);
        if (bus_req_o || stall_o != 6'b0) bad++;
      end
      chk("post_rst_nop_idle", 32'(bad), 0);
    end

    repeat (3) @(negedge clk);
    chk("rsp_queue_empty", 32'(exp_q.size()), 0);
    chk("bus_queue_empty", 32'(bus_q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
